// File: rtl/imm_materializer_pkg.sv
// Shared definitions for the wide-immediate encode path.
//   - MOVZ/MOVK 64-bit opcode bases (hw, imm16 and rd fields zero)
//   - Sign-extender control codes (Z mode decodes imm16 << 16*hw)
//   - FSM state encoding for imm_materializer
//   - Helpers: non-zero halfword mask, halfword select, instruction packing
package imm_materializer_pkg;

  localparam logic [31:0] MOVZ_BASE = 32'hD280_0000;
  localparam logic [31:0] MOVK_BASE = 32'hF280_0000;

  typedef enum logic [2:0] {
    SE_I  = 3'b000,
    SE_D  = 3'b001,
    SE_B  = 3'b010,
    SE_CB = 3'b011,
    SE_Z  = 3'b100
  } se_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit i set when halfword i of v is non-zero.
  function automatic logic [3:0] nz_mask(input logic [63:0] v);
    logic [3:0] m;
    m[0] = (v[15:0]  != 16'h0);
    m[1] = (v[31:16] != 16'h0);
    m[2] = (v[47:32] != 16'h0);
    m[3] = (v[63:48] != 16'h0);
    return m;
  endfunction

  function automatic logic [15:0] hw_slice(input logic [63:0] v, input logic [1:0] hw);
    logic [15:0] s;
    case (hw)
      2'd0:    s = v[15:0];
      2'd1:    s = v[31:16];
      2'd2:    s = v[47:32];
      default: s = v[63:48];
    endcase
    return s;
  endfunction

  // The first beat of a request is always MOVZ so stale upper bits are wiped.
  function automatic logic [31:0] encode_mov(input logic first, input logic [1:0] hw,
                                             input logic [15:0] imm, input logic [4:0] rd);
    logic [31:0] base;
    base = first ? MOVZ_BASE : MOVK_BASE;
    return base | {9'b0, hw, imm, rd};
  endfunction

endpackage

// File: rtl/hw_pick.sv
// Lowest-set-bit priority encoder over the pending-halfword mask.
//   mask_i [3:0] : pending halfwords
//   hw_o   [1:0] : index of the lowest pending halfword (0 when none)
//   any_o        : at least one halfword pending
module hw_pick (
  input  logic [3:0] mask_i,
  output logic [1:0] hw_o,
  output logic       any_o
);

  always_comb begin
    hw_o  = 2'd0;
    any_o = |mask_i;
    if (mask_i[0])      hw_o = 2'd0;
    else if (mask_i[1]) hw_o = 2'd1;
    else if (mask_i[2]) hw_o = 2'd2;
    else if (mask_i[3]) hw_o = 2'd3;
  end

endmodule

// File: rtl/imm_materializer.sv
// Emits the MOVZ/MOVK sequence that rebuilds a 64-bit constant in register rd,
// one 32-bit instruction per valid/ready handshake, halfwords in ascending order.
// Ports:
//   CLK, Reset         : clock, synchronous active-high reset
//   start, value, rd   : request (sampled only in IDLE)
//   instr, instr_valid : instruction stream, held stable under backpressure
//   instr_ready        : consumer accepts instr this cycle
//   busy               : request in progress (EMIT/DONE)
//   done               : one-cycle pulse after the last beat is accepted
//   count              : beats accepted for the current/last request
module imm_materializer
  import imm_materializer_pkg::*;
#(
  parameter bit SKIP_ZERO_HW = 1'b1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        start,
  input  logic [63:0] value,
  input  logic [4:0]  rd,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        busy,
  output logic        done,
  output logic [2:0]  count
);

  state_e      state_q;
  logic [63:0] value_q;
  logic [4:0]  rd_q;
  logic [3:0]  mask_q, mask_d;
  logic [1:0]  hw_q;
  logic        first_q, first_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q;
  logic        busy_q;
  logic        done_q;
  logic [2:0]  count_q;

  logic        accept;
  logic        fire;
  logic [63:0] val_sel;
  logic [4:0]  rd_sel;
  logic [1:0]  pick_hw;
  logic        pick_any;

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign count       = count_q;

  // Next pending mask: fresh on accept, current beat retired on fire.
  // The following beat is picked from this mask so instr can be registered.
  always_comb begin
    accept  = (state_q == ST_IDLE) && start;
    fire    = (state_q == ST_EMIT) && instr_valid_q && instr_ready;
    mask_d  = mask_q;
    first_d = first_q;
    val_sel = value_q;
    rd_sel  = rd_q;
    if (accept) begin
      if (!SKIP_ZERO_HW)       mask_d = 4'b1111;
      else if (value == 64'h0) mask_d = 4'b0001;
      else                     mask_d = nz_mask(value);
      first_d = 1'b1;
      val_sel = value;
      rd_sel  = rd;
    end else if (fire) begin
      mask_d  = mask_q & ~(4'b0001 << hw_q);
      first_d = 1'b0;
    end
  end

  hw_pick u_hw_pick (
    .mask_i (mask_d),
    .hw_o   (pick_hw),
    .any_o  (pick_any)
  );

  always_comb begin
    instr_d = encode_mov(first_d, pick_hw, hw_slice(val_sel, pick_hw), rd_sel);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      value_q       <= 64'h0;
      rd_q          <= 5'h0;
      mask_q        <= 4'h0;
      hw_q          <= 2'd0;
      first_q       <= 1'b0;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      count_q       <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            value_q       <= value;
            rd_q          <= rd;
            count_q       <= 3'd0;
            mask_q        <= mask_d;
            hw_q          <= pick_hw;
            first_q       <= 1'b1;
            instr_q       <= instr_d;
            instr_valid_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (fire) begin
            count_q <= count_q + 3'd1;
            mask_q  <= mask_d;
            first_q <= 1'b0;
            if (pick_any) begin
              hw_q    <= pick_hw;
              instr_q <= instr_d;
            end else begin
              instr_q       <= 32'h0;
              instr_valid_q <= 1'b0;
              done_q        <= 1'b1;
              state_q       <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_materializer.sv
// Scoreboard bench for imm_materializer: stimulus pushes expected words,
// negedge monitors pop and compare on every accepted beat.
module tb_imm_materializer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start4, ready;
  logic [63:0] value;
  logic [4:0]  rd;

  logic [31:0] instr, instr4;
  logic        instr_valid, instr_valid4;
  logic        busy, busy4, done, done4;
  logic [2:0]  count, count4;

  imm_materializer #(.SKIP_ZERO_HW(1'b1)) u_dut (
    .CLK(clk), .Reset(rst), .start(start), .value(value), .rd(rd),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(ready),
    .busy(busy), .done(done), .count(count)
  );

  imm_materializer #(.SKIP_ZERO_HW(1'b0)) u_dut4 (
    .CLK(clk), .Reset(rst), .start(start4), .value(value), .rd(rd),
    .instr(instr4), .instr_valid(instr_valid4), .instr_ready(ready),
    .busy(busy4), .done(done4), .count(count4)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_fire = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] q[$];
  logic [31:0] q4[$];
  logic [63:0] cur_val;
  logic [63:0] cpu_reg;
  logic [63:0] zext;
  logic [31:0] mon_exp, mon4_exp, prev_instr;
  logic [1:0]  mon_hw;
  bit          prev_stall = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Main monitor: scoreboard, stall stability, Z-mode decode and CPU model.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("stall_valid", {63'b0, instr_valid}, 64'd1);
        check("stall_instr", {32'b0, instr}, {32'b0, prev_instr});
      end
      if (instr_valid && ready) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got %h, expected no beat", instr);
        end else begin
          mon_exp = q.pop_front();
          check("beat", {32'b0, instr}, {32'b0, mon_exp});
        end
        mon_hw = instr[22:21];
        zext   = {48'b0, instr[20:5]} << (16 * mon_hw);
        check("zmode", zext, cur_val & (64'hFFFF << (16 * mon_hw)));
        if (!instr[29]) cpu_reg = zext;
        else            cpu_reg = (cpu_reg & ~(64'hFFFF << (16 * mon_hw))) | zext;
        last_fire = cyc;
      end
      prev_stall = instr_valid && !ready;
      prev_instr = instr;
    end else begin
      prev_stall = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && instr_valid4 && ready) begin
      if (q4.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_beat4: got %h, expected no beat", instr4);
      end else begin
        mon4_exp = q4.pop_front();
        check("beat4", {32'b0, instr4}, {32'b0, mon4_exp});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Pulse start; value/rd are scrambled afterwards to prove they were captured.
  task automatic issue(input logic [63:0] v, input logic [4:0] r, input bit to4);
    tick();
    value = v; rd = r;
    if (!to4) begin
      cur_val = v;
      cpu_reg = 64'hA5A5_5A5A_C3C3_3C3C;
    end
    if (to4) start4 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0; start4 = 1'b0;
    value = ~v; rd = ~r;
  endtask

  task automatic wait_done(input string name, input int exp_cnt, input bit to4);
    bit got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (to4 ? done4 : done) begin got = 1'b1; break; end
    end
    check({name, "_done_seen"}, {63'b0, got}, 64'd1);
    if (got) begin
      if (to4) begin
        check({name, "_count"}, {61'b0, count4}, exp_cnt);
        check({name, "_queue_empty"}, q4.size(), 64'd0);
      end else begin
        check({name, "_count"}, {61'b0, count}, exp_cnt);
        check({name, "_busy_in_done"}, {63'b0, busy}, 64'd1);
        check({name, "_valid_in_done"}, {63'b0, instr_valid}, 64'd0);
        check({name, "_done_latency"}, cyc - last_fire, 64'd1);
        check({name, "_queue_empty"}, q.size(), 64'd0);
        check({name, "_cpu_reg"}, cpu_reg, cur_val);
      end
      @(negedge clk);
      check({name, "_done_pulse_end"}, {63'b0, to4 ? done4 : done}, 64'd0);
      check({name, "_busy_idle"}, {63'b0, to4 ? busy4 : busy}, 64'd0);
      check({name, "_valid_idle"}, {63'b0, to4 ? instr_valid4 : instr_valid}, 64'd0);
    end
  endtask

  // Independent reference: ascending non-zero halfwords, MOVZ first.
  function automatic int push_model(input logic [63:0] v, input logic [4:0] r);
    int n = 0;
    logic [15:0] h;
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      h = v[16*i +: 16];
      if (h != 16'h0 || (v == 64'h0 && i == 0)) begin
        w = (n == 0) ? 32'hD280_0000 : 32'hF280_0000;
        w[22:21] = i[1:0];
        w[20:5]  = h;
        w[4:0]   = r;
        q.push_back(w);
        n++;
      end
    end
    return n;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [63:0] rv;
    int n;
    rst = 1'b1; start = 1'b0; start4 = 1'b0; ready = 1'b1;
    value = 64'h0; rd = 5'h0; cur_val = 64'h0; cpu_reg = 64'h0;
    repeat (3) tick();
    check("rst_instr", {32'b0, instr}, 64'd0);
    check("rst_valid", {63'b0, instr_valid}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_count", {61'b0, count}, 64'd0);
    rst = 1'b0;

    // Single low halfword.
    q.push_back(32'hD282_4683);
    issue(64'h0000_0000_0000_1234, 5'd3, 1'b0);
    wait_done("v1234", 1, 1'b0);

    // Sparse halfwords: MOVZ hw1 then MOVK hw3.
    q.push_back(32'hD2B7_DDE0);
    q.push_back(32'hF2FB_D5A0);
    issue(64'hDEAD_0000_BEEF_0000, 5'd0, 1'b0);
    wait_done("vdead", 2, 1'b0);

    // Zero value: single MOVZ of hw0.
    q.push_back(32'hD280_001F);
    issue(64'h0, 5'd31, 1'b0);
    wait_done("vzero", 1, 1'b0);

    // No skipping: four beats for value 1.
    q4.push_back(32'hD280_0022);
    q4.push_back(32'hF2A0_0002);
    q4.push_back(32'hF2C0_0002);
    q4.push_back(32'hF2E0_0002);
    issue(64'h1, 5'd2, 1'b1);
    wait_done("noskip", 4, 1'b1);

    // Backpressure pattern with an ignored start mid-sequence.
    q.push_back(32'hD288_8885);
    q.push_back(32'hF2A6_6665);
    q.push_back(32'hF2C4_4445);
    q.push_back(32'hF2E2_2225);
    issue(64'h1111_2222_3333_4444, 5'd5, 1'b0);
    for (int i = 0; i < 7; i++) begin
      ready = pat[i];
      if (i == 2) begin value = 64'h0000_0000_0000_00FF; start = 1'b1; end
      tick();
      start = 1'b0;
    end
    ready = 1'b1;
    wait_done("stall", 4, 1'b0);

    // Reset while the 2nd of 4 beats is presented.
    q.push_back(32'hD288_8885);
    q.push_back(32'hF2A6_6665);
    q.push_back(32'hF2C4_4445);
    q.push_back(32'hF2E2_2225);
    issue(64'h1111_2222_3333_4444, 5'd5, 1'b0);
    tick();
    rst = 1'b1; ready = 1'b0;
    tick();
    check("abort_instr", {32'b0, instr}, 64'd0);
    check("abort_valid", {63'b0, instr_valid}, 64'd0);
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_count", {61'b0, count}, 64'd0);
    q.delete();
    rst = 1'b0; ready = 1'b1;
    tick(); tick();
    check("abort_stays_idle", {63'b0, instr_valid}, 64'd0);
    q.push_back(32'hD2B7_DDE0);
    q.push_back(32'hF2FB_D5A0);
    issue(64'hDEAD_0000_BEEF_0000, 5'd0, 1'b0);
    wait_done("after_abort", 2, 1'b0);

    // Random constants rebuilt by the CPU model.
    for (int k = 0; k < 16; k++) begin
      rv = {$urandom, $urandom};
      for (int i = 0; i < 4; i++)
        if ($urandom_range(1, 0) == 0) rv[16*i +: 16] = 16'h0;
      n = push_model(rv, 5'($urandom_range(31, 0)));
      issue(rv, q[0][4:0], 1'b0);
      wait_done("random", n, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
